led_chase_monitor: RTL and testbench
====================================

# led_chase_monitor

Receive-side checker for the 16-bit LED chaser output bus. It samples the walking one-hot pattern and locks onto the sequence. Once locked it reports the lit position, counts completed laps and flags every deviation from the expected shift order. It sits beside the chaser in the board top, or in the bench, and consumes the same 16-bit bus that drives the LEDs.

## Interface
- WIDTH, 16, width of the LED bus
- WRAP_POS, 14, highest lit position before the chaser returns to position 0; sequence period is WRAP_POS+1
- LOCK_N, 4, consecutive correct steps required before `locked` asserts
- ERRW, 8, width of the saturating error counter

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ledin  in  WIDTH  LED bus under test
- pos  out  4  index of the lit bit for the last accepted sample
- pos_valid  out  1  one-cycle pulse per accepted (in-sequence) sample
- locked  out  1  high after LOCK_N consecutive correct steps
- lap_pulse  out  1  one-cycle pulse when position WRAP_POS is followed by position 0
- lap_cnt  out  16  completed laps, wraps modulo 2^16
- err  out  1  one-cycle pulse on a sequence violation
- err_cnt  out  ERRW  violations since reset, saturates at all-ones

## Operation
- Input stage: `ledin` is registered into `ledin_q` every cycle. All decisions use `ledin_q`.
- Decode of `ledin_q`:
  - `zero` = no bit set.
  - `hot` = exactly one bit set.
  - `idx` = index of the set bit.
  - A set bit above WRAP_POS counts as not `hot`.
- State machine states: IDLE, TRACK.
- IDLE:
  - `zero` is ignored; the chaser idles at zero for one cycle after its reset.
  - `hot` with idx==0 → TRACK, `exp` = 1, pos=0, pos_valid=1, run counter = 1.
  - Any other non-zero value → stay in IDLE, no err.
- TRACK, sample `hot` and idx==`exp`:
  - pos=idx, pos_valid=1.
  - `exp` advances to idx+1, or to 0 when idx==WRAP_POS.
  - Run counter increments and saturates at LOCK_N.
  - If idx==0 (meaning previous was WRAP_POS): lap_pulse=1 and lap_cnt+1.
- TRACK, any other sample (zero, multi-hot, wrong index):
  - err=1, err_cnt+1 (saturating), locked drops, run counter cleared.
  - If the sample is `hot` with idx==0 → stay in TRACK and restart with `exp`=1. This is an immediate resync and is counted as the single error.
  - Otherwise → IDLE.
- `locked` = TRACK and run counter == LOCK_N.
- Simultaneous lap and lock: both take effect in the same cycle.
- `lap_cnt` 0xFFFF + 1 → 0x0000.
- `err_cnt` holds at all-ones. err still pulses.
- Reset mid-operation discards all state. No partial lap is counted.

## Timing
- Reset values:
  - pos=0, pos_valid=0, locked=0, lap_pulse=0, lap_cnt=0, err=0, err_cnt=0.
  - State IDLE, `exp`=0, run counter=0, `ledin_q`=0.
- Latency from `ledin` to outputs: 2 cycles. A value on `ledin` before edge k is in `ledin_q` after edge k, and its outputs appear after edge k+1.
- pos_valid, lap_pulse and err are single-cycle pulses.
- pos_valid and err are mutually exclusive.
- pos, lap_cnt and err_cnt hold between events.
- Throughput: one sample per clock. No stall or handshake; the bus is free-running.

## Structure
- Shared package `led_pkg` holds:
  - the state enum (IDLE, TRACK);
  - constants LED_WIDTH=16 and LED_WRAP_POS=14, which the chaser and the monitor both use.
- One sub-module, `onehot_dec`. It is purely combinational: WIDTH in, `zero`/`hot`/`idx` out, with `hot` qualified against WRAP_POS.
- Everything else is in the top: input register, FSM, `exp`, run counter, lap counter, error counter.

## Test plan
- Reset, then drive 0, 0x0001, 0x0002 … 0x4000, 0x0001 ×3 laps:
  - pos_valid every cycle from the first 0x0001, 2-cycle latency;
  - locked after 4 correct steps;
  - lap_pulse ×3, lap_cnt=3, err_cnt=0.
- Locked at pos 5, drive 0x0060 (two-hot): err pulse, err_cnt=1, locked=0, state IDLE. The next 0x0001 relocks.
- Locked at pos 9, drive 0x0001: err=1, err_cnt=1, remains in TRACK. 0x0002 is then accepted; locked returns after 4 correct steps.
- Locked, drive 0x0000 for one cycle: err, IDLE. Further zeros produce no err.
- Preload error condition 300 times with ERRW=8: err_cnt stops at 255, err still pulses.
- Assert rst for one cycle mid-lap at pos 7: all outputs reset next cycle. The sequence resuming at 0x0100 is ignored until 0x0001.

Source files
------------

// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED chaser and its receive-side monitor.
//   LED_WIDTH    : width of the LED bus driven by the chaser
//   LED_WRAP_POS : highest lit position before the chaser returns to 0
//   mon_state_t  : monitor sequencing states (IDLE, TRACK)
// ---------------------------------------------------------------------------
package led_pkg;

  localparam int LED_WIDTH    = 16;
  localparam int LED_WRAP_POS = 14;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    TRACK = 1'b1
  } mon_state_t;

endpackage : led_pkg

// File: rtl/onehot_dec.sv
// ---------------------------------------------------------------------------
// onehot_dec
// Purely combinational decode of one LED bus sample.
// Ports:
//   vec  in  WIDTH  sample to decode
//   zero out 1      no bit set
//   hot  out 1      exactly one bit set, at a position not above WRAP_POS
//   idx  out IDXW   index of the (highest) set bit
// ---------------------------------------------------------------------------
module onehot_dec #(
  parameter int WIDTH    = 16,
  parameter int WRAP_POS = 14,
  parameter int IDXW     = 4
) (
  input  logic [WIDTH-1:0] vec,
  output logic             zero,
  output logic             hot,
  output logic [IDXW-1:0]  idx
);

  localparam logic [IDXW-1:0]  WRAP_IDX = IDXW'(WRAP_POS);
  localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic single_s;

  // Classify the sample: empty, single bit (v & (v-1) clears the lowest set bit), and its index.
  always_comb begin
    zero     = (vec == {WIDTH{1'b0}});
    single_s = (!zero) && ((vec & (vec - ONE_W)) == {WIDTH{1'b0}});
    idx      = {IDXW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      idx = vec[i] ? IDXW'(i) : idx;
    end
    // A lone bit beyond the wrap position is never part of a valid chase.
    hot      = single_s && (idx <= WRAP_IDX);
  end

endmodule : onehot_dec

// File: rtl/led_chase_monitor.sv
// ---------------------------------------------------------------------------
// led_chase_monitor
// Receive-side checker for the walking one-hot LED chaser bus. Locks onto the
// sequence, reports the lit position, counts laps and flags deviations.
// Ports:
//   clk       in  1      clock, all state on rising edge
//   rst       in  1      synchronous active-high reset
//   ledin     in  WIDTH  LED bus under test
//   pos       out 4      lit index of the last accepted sample
//   pos_valid out 1      pulse per accepted sample
//   locked    out 1      LOCK_N consecutive correct steps seen
//   lap_pulse out 1      pulse when WRAP_POS is followed by 0
//   lap_cnt   out 16     completed laps, wraps
//   err       out 1      pulse per sequence violation
//   err_cnt   out ERRW   violations since reset, saturating
// Latency: ledin -> outputs is two clocks (input register + decision register).
// ---------------------------------------------------------------------------
module led_chase_monitor
  import led_pkg::*;
#(
  parameter int WIDTH    = LED_WIDTH,
  parameter int WRAP_POS = LED_WRAP_POS,
  parameter int LOCK_N   = 4,
  parameter int ERRW     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ledin,
  output logic [3:0]       pos,
  output logic             pos_valid,
  output logic             locked,
  output logic             lap_pulse,
  output logic [15:0]      lap_cnt,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int IDXW = 4;
  localparam int RUNW = $clog2(LOCK_N + 1);

  localparam logic [IDXW-1:0] WRAP_IDX = IDXW'(WRAP_POS);
  localparam logic [RUNW-1:0] RUN_MAX  = RUNW'(LOCK_N);
  localparam logic [RUNW-1:0] RUN_ONE  = {{(RUNW-1){1'b0}}, 1'b1};
  localparam logic [ERRW-1:0] ERR_MAX  = {ERRW{1'b1}};
  localparam logic [ERRW-1:0] ERR_ONE  = {{(ERRW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ledin_q_r;
  mon_state_t       state_r;
  logic [IDXW-1:0]  exp_r;
  logic [RUNW-1:0]  run_r;

  logic             zero_s;
  logic             hot_s;
  logic [IDXW-1:0]  idx_s;
  logic             match_s;
  logic             restart_s;
  logic [RUNW-1:0]  run_inc_s;

  onehot_dec #(
    .WIDTH    (WIDTH),
    .WRAP_POS (WRAP_POS),
    .IDXW     (IDXW)
  ) u_dec (
    .vec  (ledin_q_r),
    .zero (zero_s),
    .hot  (hot_s),
    .idx  (idx_s)
  );

  // Step qualifiers derived from the registered sample.
  always_comb begin
    match_s   = hot_s && (idx_s == exp_r);
    restart_s = hot_s && (idx_s == {IDXW{1'b0}});
    run_inc_s = (run_r == RUN_MAX) ? RUN_MAX : (run_r + RUN_ONE);
  end

  // Input register, sequencing FSM and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ledin_q_r <= {WIDTH{1'b0}};
      state_r   <= IDLE;
      exp_r     <= {IDXW{1'b0}};
      run_r     <= {RUNW{1'b0}};
      pos       <= 4'd0;
      pos_valid <= 1'b0;
      locked    <= 1'b0;
      lap_pulse <= 1'b0;
      lap_cnt   <= 16'd0;
      err       <= 1'b0;
      err_cnt   <= {ERRW{1'b0}};
    end else begin
      ledin_q_r <= ledin;
      pos_valid <= 1'b0;
      lap_pulse <= 1'b0;
      err       <= 1'b0;
      case (state_r)
        IDLE: begin
          if (restart_s) begin
            state_r   <= TRACK;
            exp_r     <= 4'd1;
            pos       <= 4'd0;
            pos_valid <= 1'b1;
            run_r     <= RUN_ONE;
            locked    <= (RUN_ONE == RUN_MAX);
          end else if (zero_s) begin
            // The chaser sits at zero for a cycle after its own reset; not an error.
            state_r <= IDLE;
            locked  <= 1'b0;
          end else begin
            // Any other pattern while searching is simply not a start point.
            state_r <= IDLE;
            locked  <= 1'b0;
          end
        end
        TRACK: begin
          if (match_s) begin
            pos       <= idx_s;
            pos_valid <= 1'b1;
            exp_r     <= (idx_s == WRAP_IDX) ? 4'd0 : (idx_s + 4'd1);
            run_r     <= run_inc_s;
            locked    <= (run_inc_s == RUN_MAX);
            // An accepted 0 in TRACK can only follow WRAP_POS: a lap just closed.
            if (idx_s == 4'd0) begin
              lap_pulse <= 1'b1;
              lap_cnt   <= lap_cnt + 16'd1;
            end else begin
              lap_cnt   <= lap_cnt;
            end
          end else begin
            err    <= 1'b1;
            locked <= 1'b0;
            run_r  <= {RUNW{1'b0}};
            if (err_cnt != ERR_MAX) begin
              err_cnt <= err_cnt + ERR_ONE;
            end else begin
              err_cnt <= err_cnt;
            end
            // An out-of-order 0 is a fresh start: resync at once, one error only.
            if (restart_s) begin
              state_r <= TRACK;
              exp_r   <= 4'd1;
            end else begin
              state_r <= IDLE;
              exp_r   <= 4'd0;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          exp_r   <= {IDXW{1'b0}};
          run_r   <= {RUNW{1'b0}};
          locked  <= 1'b0;
        end
      endcase
    end
  end

endmodule : led_chase_monitor

// File: tb/tb_led_chase_monitor.sv
// ---------------------------------------------------------------------------
// tb_led_chase_monitor
// Directed self-checking bench for led_chase_monitor. Each tick drives one bus
// value; the outputs observed after it belong to the value driven one tick
// earlier (two-clock latency). Output rows are packed as
// {pos[3:0], pos_valid, locked, lap_pulse, err}.
// ---------------------------------------------------------------------------
module tb_led_chase_monitor;

  logic        clk;
  logic        rst;
  logic [15:0] ledin;
  logic [3:0]  pos;
  logic        pos_valid;
  logic        locked;
  logic        lap_pulse;
  logic [15:0] lap_cnt;
  logic        err;
  logic [7:0]  err_cnt;

  int checks;
  int errors;

  led_chase_monitor #(
    .WIDTH    (16),
    .WRAP_POS (14),
    .LOCK_N   (4),
    .ERRW     (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ledin     (ledin),
    .pos       (pos),
    .pos_valid (pos_valid),
    .locked    (locked),
    .lap_pulse (lap_pulse),
    .lap_cnt   (lap_cnt),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one bus value across a rising edge and settle just after it.
  task automatic tick(input logic [15:0] v);
    ledin = v;
    @(posedge clk);
    #1;
  endtask

  // Single-cycle reset with a quiet bus.
  task automatic do_reset();
    rst = 1'b1;
    tick(16'h0000);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(16'hFFFF);
    tick(16'hFFFF);
    rst = 1'b0;
    checks++;
    if ({pos, pos_valid, locked, lap_pulse, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outs got %h want %h", {pos, pos_valid, locked, lap_pulse, err}, 8'h00);
    end
    checks++;
    if ({lap_cnt, err_cnt} !== 24'h000000) begin
      errors++;
      $display("FAIL reset_counters got %h want %h", {lap_cnt, err_cnt}, 24'h000000);
    end
    tick(16'h0000);
    checks++;
    if ({pos, pos_valid, locked, lap_pulse, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_flushed got %h want %h", {pos, pos_valid, locked, lap_pulse, err}, 8'h00);
    end
  endtask

  // Three full laps from a clean start, then one extra step.
  task automatic test_laps();
    logic [15:0] v;
    logic [7:0]  want;
    logic [15:0] want_lap;
    int k;
    do_reset();
    for (int j = 0; j <= 46; j++) begin
      v = (j <= 45) ? (16'h0001 << (j % 15)) : 16'h0002;
      tick(v);
      if (j == 0) begin
        want     = 8'h00;
        want_lap = 16'd0;
      end else begin
        k        = j - 1;
        want     = {4'(k % 15), 1'b1, (k >= 3), (k >= 15 && (k % 15) == 0), 1'b0};
        want_lap = 16'(k / 15);
      end
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== want) begin
        errors++;
        $display("FAIL laps_outs step %0d got %h want %h", j, {pos, pos_valid, locked, lap_pulse, err}, want);
      end
      checks++;
      if (lap_cnt !== want_lap || err_cnt !== 8'd0) begin
        errors++;
        $display("FAIL laps_counters step %0d got lap %0d err %0d want lap %0d err 0", j, lap_cnt, err_cnt, want_lap);
      end
    end
  endtask

  // Continues from test_laps: reset one cycle while at position 7.
  task automatic test_reset_mid();
    logic [15:0] drv [13];
    logic        rs  [13];
    logic [7:0]  wo  [13];
    logic [15:0] wl  [13];
    drv = '{16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080, 16'h0100,
            16'h0200, 16'h0100, 16'h0200, 16'h0001, 16'h0002, 16'h0004};
    rs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    wo  = '{8'h1C, 8'h2C, 8'h3C, 8'h4C, 8'h5C, 8'h6C, 8'h7C,
            8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h18};
    wl  = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3, 16'd3,
            16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 13; i++) begin
      rst = rs[i];
      tick(drv[i]);
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== wo[i]) begin
        errors++;
        $display("FAIL reset_mid_outs row %0d got %h want %h", i, {pos, pos_valid, locked, lap_pulse, err}, wo[i]);
      end
      checks++;
      if (lap_cnt !== wl[i] || err_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_mid_counters row %0d got lap %0d err %0d want lap %0d err 0", i, lap_cnt, err_cnt, wl[i]);
      end
    end
    rst = 1'b0;
  endtask

  // A constant 0x0001 in TRACK is an out-of-order restart every cycle.
  task automatic test_err_sat();
    logic [7:0] want_cnt;
    do_reset();
    tick(16'h0001);
    tick(16'h0001);
    checks++;
    if ({pos, pos_valid, locked, lap_pulse, err} !== 8'h08) begin
      errors++;
      $display("FAIL err_sat_start got %h want %h", {pos, pos_valid, locked, lap_pulse, err}, 8'h08);
    end
    for (int i = 0; i < 300; i++) begin
      tick(16'h0001);
      want_cnt = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== 8'h01 || err_cnt !== want_cnt) begin
        errors++;
        $display("FAIL err_sat error %0d got outs %h cnt %0d want outs 01 cnt %0d",
                 i + 1, {pos, pos_valid, locked, lap_pulse, err}, err_cnt, want_cnt);
      end
    end
  endtask

  // Two-hot value while locked at 5 drops to IDLE; 0x0001 then relocks.
  task automatic test_multi_hot();
    logic [15:0] drv [12];
    logic [7:0]  wo  [12];
    logic [7:0]  wc  [12];
    drv = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020,
            16'h0060, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010};
    wo  = '{8'h00, 8'h08, 8'h18, 8'h28, 8'h3C, 8'h4C,
            8'h5C, 8'h51, 8'h08, 8'h18, 8'h28, 8'h3C};
    wc  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      tick(drv[i]);
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== wo[i] || err_cnt !== wc[i]) begin
        errors++;
        $display("FAIL multi_hot row %0d got outs %h cnt %0d want outs %h cnt %0d",
                 i, {pos, pos_valid, locked, lap_pulse, err}, err_cnt, wo[i], wc[i]);
      end
    end
  endtask

  // Early 0x0001 while locked at 9: single error, stays in TRACK.
  task automatic test_resync();
    logic [15:0] drv [16];
    logic [7:0]  wo  [16];
    logic [7:0]  wc  [16];
    drv = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080,
            16'h0100, 16'h0200, 16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0020};
    wo  = '{8'h00, 8'h08, 8'h18, 8'h28, 8'h3C, 8'h4C, 8'h5C, 8'h6C,
            8'h7C, 8'h8C, 8'h9C, 8'h91, 8'h18, 8'h28, 8'h38, 8'h4C};
    wc  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0,
            8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick(drv[i]);
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== wo[i] || err_cnt !== wc[i]) begin
        errors++;
        $display("FAIL resync row %0d got outs %h cnt %0d want outs %h cnt %0d",
                 i, {pos, pos_valid, locked, lap_pulse, err}, err_cnt, wo[i], wc[i]);
      end
    end
  endtask

  // Zero while locked: one error then IDLE; more zeros and bit 15 are ignored.
  task automatic test_zero();
    logic [15:0] drv [11];
    logic [7:0]  wo  [11];
    logic [7:0]  wc  [11];
    drv = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0010, 16'h0000,
            16'h0000, 16'h0000, 16'h8000, 16'h0001, 16'h0002};
    wo  = '{8'h00, 8'h08, 8'h18, 8'h28, 8'h3C, 8'h4C, 8'h41, 8'h40, 8'h40, 8'h40, 8'h08};
    wc  = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick(drv[i]);
      checks++;
      if ({pos, pos_valid, locked, lap_pulse, err} !== wo[i] || err_cnt !== wc[i]) begin
        errors++;
        $display("FAIL zero row %0d got outs %h cnt %0d want outs %h cnt %0d",
                 i, {pos, pos_valid, locked, lap_pulse, err}, err_cnt, wo[i], wc[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    ledin  = 16'h0000;
    test_reset();
    test_laps();
    test_reset_mid();
    test_err_sat();
    test_multi_hot();
    test_resync();
    test_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_led_chase_monitor
